// File: rtl/adc_scan_sched_if.sv
// Bundle between the acquisition requesters, the ADC controller and adc_scan_sched.
// The slave modport is the scheduler's view; master is the environment driving it.
interface adc_scan_sched_if #(
  parameter int NCH  = 4,
  parameter int CH_W = 2
);
  logic [NCH-1:0]  req;
  logic [CH_W-1:0] mux_sel;
  logic            adc_start;
  logic            adc_done;
  logic [15:0]     adc_data;
  logic [NCH-1:0]  rd_valid;
  logic [15:0]     rd_data;
  logic            busy;
  logic            err;

  modport master (
    output req, adc_done, adc_data,
    input  mux_sel, adc_start, rd_valid, rd_data, busy, err
  );

  modport slave (
    input  req, adc_done, adc_data,
    output mux_sel, adc_start, rd_valid, rd_data, busy, err
  );
endinterface

// File: rtl/adc_scan_sched.sv
// Round-robin scheduler sharing one ADC conversion controller between NCH requesters.
// Define ADC_TIMEOUT_EN to add the done watchdog (TIMEOUT cycles) and the err strobe.
//
// state   | meaning
// IDLE    | sample req, pick next requester round-robin from rr_ptr
// SEL     | drive mux_sel for the granted channel, clear settle counter
// SETTLE  | wait SETTLE cycles for the analog mux to settle
// START   | one-cycle adc_start pulse
// WAIT    | wait for a rising edge of adc_done (or watchdog expiry)
// CAPT    | one cycle for adc_data to update after the done edge
// DELIVER | register result, strobe rd_valid, advance rr_ptr
module adc_scan_sched #(
  parameter int          NCH     = 4,
  parameter int          CH_W    = 2,
  parameter logic [7:0]  SETTLE  = 8'd40,
  parameter logic [15:0] TIMEOUT = 16'd4000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  adc_scan_sched_if.slave  io_bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEL, S_SETTLE, S_START, S_WAIT, S_CAPT, S_DELIVER
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CH_W-1:0] r_gnt;
  logic [CH_W-1:0] r_rr_ptr;
  logic [CH_W-1:0] r_mux_sel;
  logic [CH_W-1:0] w_pick;
  logic [CH_W-1:0] w_gnt_inc;
  logic [CH_W:0]   w_idx;
  logic            w_any;
  logic [7:0]      r_settle_cnt;
  logic            r_done_d;
  logic            w_done_rise;
  logic            w_timeout;
  logic [NCH-1:0]  r_rd_valid;
  logic [NCH-1:0]  w_gnt_oh;
  logic [15:0]     r_rd_data;
  logic            w_adc_start;
  logic            w_busy;

  // First requester at or above rr_ptr, wrapping modulo NCH.
  always_comb begin
    w_pick = '0;
    w_any  = 1'b0;
    w_idx  = '0;
    for (int i = 0; i < NCH; i++) begin
      w_idx = {1'b0, r_rr_ptr} + (CH_W+1)'(i);
      if (w_idx >= (CH_W+1)'(NCH)) w_idx = w_idx - (CH_W+1)'(NCH);
      if (!w_any && io_bus.req[w_idx[CH_W-1:0]]) begin
        w_any  = 1'b1;
        w_pick = w_idx[CH_W-1:0];
      end
    end
  end

  assign w_gnt_inc   = (r_gnt == CH_W'(NCH-1)) ? '0 : r_gnt + CH_W'(1);
  assign w_gnt_oh    = NCH'(1) << r_gnt;
  assign w_done_rise = io_bus.adc_done & ~r_done_d;

`ifdef ADC_TIMEOUT_EN
  logic [15:0] r_wdog;
  logic        r_err;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_timeout;
      if (w_next == S_SEL)
        r_wdog <= '0;
      else if (r_state == S_WAIT || r_state == S_CAPT)
        r_wdog <= r_wdog + 16'd1;
    end
  end

  assign w_timeout  = (r_state == S_WAIT) && !w_done_rise && (r_wdog == TIMEOUT - 16'd1);
  assign io_bus.err = r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT;
  assign w_timeout        = 1'b0;
  assign io_bus.err       = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_adc_start = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (w_any) w_next = S_SEL;
      end
      S_SEL:    w_next = S_SETTLE;
      S_SETTLE: if (r_settle_cnt == SETTLE - 8'd1) w_next = S_START;
      S_START: begin
        w_adc_start = 1'b1;
        w_next      = S_WAIT;
      end
      S_WAIT: begin
        if (w_done_rise)    w_next = S_CAPT;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_CAPT:    w_next = S_DELIVER;
      S_DELIVER: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_gnt        <= '0;
      r_rr_ptr     <= '0;
      r_mux_sel    <= '0;
      r_settle_cnt <= '0;
      r_done_d     <= 1'b0;
      r_rd_valid   <= '0;
      r_rd_data    <= '0;
    end else begin
      // Tracked every cycle so a done already high on WAIT entry is not an edge.
      r_done_d   <= io_bus.adc_done;
      r_rd_valid <= '0;
      case (r_state)
        S_IDLE: if (w_any) r_gnt <= w_pick;
        S_SEL: begin
          r_mux_sel    <= r_gnt;
          r_settle_cnt <= '0;
        end
        S_SETTLE: r_settle_cnt <= r_settle_cnt + 8'd1;
        S_WAIT: begin
          if (w_timeout) begin
            r_rd_data  <= 16'hFFFF;
            r_rd_valid <= w_gnt_oh;
            r_rr_ptr   <= w_gnt_inc;
          end
        end
        S_DELIVER: begin
          r_rd_data  <= io_bus.adc_data;
          r_rd_valid <= w_gnt_oh;
          r_rr_ptr   <= w_gnt_inc;
        end
        default: ;
      endcase
    end
  end

  assign io_bus.mux_sel   = r_mux_sel;
  assign io_bus.adc_start = w_adc_start;
  assign io_bus.rd_valid  = r_rd_valid;
  assign io_bus.rd_data   = r_rd_data;
  assign io_bus.busy      = w_busy;

endmodule

// File: tb/tb_adc_scan_sched.sv
// Self-checking bench for adc_scan_sched: behavioural ADC responder plus a
// round-robin reference model; define ADC_TIMEOUT_EN to exercise the watchdog.
module tb_adc_scan_sched;
  localparam int          NCH     = 4;
  localparam int          CH_W    = 2;
  localparam logic [7:0]  SETTLE  = 8'd40;
  localparam logic [15:0] TIMEOUT = 16'd100;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  adc_scan_sched_if #(.NCH(NCH), .CH_W(CH_W)) bus ();

  adc_scan_sched #(.NCH(NCH), .CH_W(CH_W), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .i_clk  (clk),
    .i_reset(reset),
    .io_bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NCH-1:0] oh;
    logic [15:0]    data;
    int             t;
  } deliv_t;

  deliv_t          obs_q[$];
  int              start_t_q[$];
  logic [CH_W-1:0] start_sel_q[$];
  int              busy_rise_q[$];
  logic [15:0]     exp_adc_q[$];
  int              rv_long  = 0;
  int              err_seen = 0;
  logic [NCH-1:0]  prev_rv  = '0;
  logic            prev_busy = 1'b0;

  // Passive observer of DUT outputs
  always @(negedge clk) begin
    deliv_t d;
    if (bus.rd_valid != '0) begin
      d.oh = bus.rd_valid; d.data = bus.rd_data; d.t = cyc;
      obs_q.push_back(d);
      if (prev_rv != '0) rv_long++;
    end
    if (bus.adc_start === 1'b1) begin
      start_t_q.push_back(cyc);
      start_sel_q.push_back(bus.mux_sel);
    end
    if (bus.busy === 1'b1 && prev_busy !== 1'b1) busy_rise_q.push_back(cyc);
    if (bus.err === 1'b1) err_seen++;
    prev_rv   = bus.rd_valid;
    prev_busy = bus.busy;
  end

  // Behavioural ADC controller: done rises adc_conv cycles after start, data one cycle later.
  bit          adc_respond = 1'b1;
  bit          adc_rand    = 1'b0;
  int          adc_conv    = 100;
  logic [15:0] adc_val     = 16'h0;
  bit          model_busy  = 1'b0;
  int          m_d;
  logic [15:0] m_v;

  initial begin
    bus.adc_done = 1'b0;
    bus.adc_data = 16'h0;
    forever begin
      @(negedge clk);
      if (bus.adc_start === 1'b1 && !reset) begin
        model_busy = 1'b1;
        if (adc_respond) begin
          m_d = adc_rand ? int'($urandom_range(1, 30)) : adc_conv;
          m_v = adc_rand ? 16'($urandom) : adc_val;
          repeat (m_d) @(negedge clk);
          bus.adc_done = 1'b1;
          bus.adc_data = ~m_v;
          @(negedge clk);
          bus.adc_data = m_v;
          exp_adc_q.push_back(m_v);
          repeat (3) @(negedge clk);
          bus.adc_done = 1'b0;
        end
        model_busy = 1'b0;
      end
    end
  end

  function automatic int ref_pick(input int rr, input logic [NCH-1:0] mask);
    for (int i = 0; i < NCH; i++)
      if (mask[(rr + i) % NCH]) return (rr + i) % NCH;
    return -1;
  endfunction

  task automatic do_reset();
    int k;
    k = 0;
    while (model_busy && k < 500) begin @(negedge clk); k++; end
    bus.req = '0;
    reset   = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    obs_q.delete(); start_t_q.delete(); start_sel_q.delete();
    busy_rise_q.delete(); exp_adc_q.delete();
  endtask

  task automatic wait_deliv(input int n, input int budget, output bit ok);
    int k;
    k  = 0;
    ok = (obs_q.size() >= n);
    while (!ok && k < budget) begin
      @(negedge clk); #1;
      k++;
      ok = (obs_q.size() >= n);
    end
  endtask

  task automatic test_reset();
    logic [24:0] v;
    bus.req = '0;
    reset   = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      v = {bus.mux_sel, bus.adc_start, bus.rd_valid, bus.rd_data, bus.busy, bus.err};
      total++;
      if (v !== 25'd0) begin bad++; $display("FAIL reset_outputs cyc=%0d got=%h exp=0", i, v); end
    end
    total++;
    if (start_t_q.size() !== 0) begin bad++; $display("FAIL reset_no_start got=%0d exp=0", start_t_q.size()); end
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    adc_rand = 1'b0; adc_conv = 100; adc_val = 16'h8123;
    bus.req = 4'b0001;
    wait_deliv(1, 400, ok);
    bus.req = '0;
    total++;
    if (!ok) begin bad++; $display("FAIL single_timeout got=no_rd_valid exp=rd_valid"); return; end
    total++;
    if (obs_q[0].oh !== 4'b0001) begin bad++; $display("FAIL single_rd_valid got=%b exp=0001", obs_q[0].oh); end
    total++;
    if (obs_q[0].data !== 16'h8123) begin bad++; $display("FAIL single_rd_data got=%h exp=8123", obs_q[0].data); end
    total++;
    if (start_sel_q.size() < 1 || start_sel_q[0] !== 2'd0) begin bad++; $display("FAIL single_mux_sel got=%0d exp=0", start_sel_q.size() ? start_sel_q[0] : 2'bxx); end
    total++;
    if (start_t_q.size() < 1 || busy_rise_q.size() < 1 || start_t_q[0] - busy_rise_q[0] !== int'(SETTLE) + 1)
      begin bad++; $display("FAIL single_sel_to_start got=%0d exp=%0d", (start_t_q.size() && busy_rise_q.size()) ? start_t_q[0] - busy_rise_q[0] : -1, int'(SETTLE) + 1); end
    total++;
    if (start_t_q.size() < 1 || obs_q[0].t - start_t_q[0] !== 103) begin bad++; $display("FAIL single_start_to_valid got=%0d exp=103", start_t_q.size() ? obs_q[0].t - start_t_q[0] : -1); end
    repeat (10) @(negedge clk); #1;
    total++;
    if (obs_q.size() !== 1) begin bad++; $display("FAIL single_no_requeue got=%0d exp=1", obs_q.size()); end
  endtask

  task automatic test_round_robin();
    bit ok;
    int rr;
    int g[5];
    logic [NCH-1:0] e;
    do_reset();
    adc_rand = 1'b1;
    bus.req  = 4'b1111;
    rr = 0;
    for (int s = 0; s < 5; s++) begin
      g[s] = ref_pick(rr, 4'b1111);
      rr   = (g[s] + 1) % NCH;
    end
    wait_deliv(5, 2000, ok);
    bus.req = '0;
    total++;
    if (!ok) begin bad++; $display("FAIL rr_timeout got=%0d exp=5", obs_q.size()); return; end
    for (int s = 0; s < 5; s++) begin
      e = NCH'(1) << g[s];
      total++;
      if (obs_q[s].oh !== e) begin bad++; $display("FAIL rr_grant s=%0d got=%b exp=%b", s, obs_q[s].oh, e); end
      total++;
      if (obs_q[s].data !== exp_adc_q[s]) begin bad++; $display("FAIL rr_data s=%0d got=%h exp=%h", s, obs_q[s].data, exp_adc_q[s]); end
      total++;
      if (start_sel_q[s] !== CH_W'(g[s])) begin bad++; $display("FAIL rr_mux_sel s=%0d got=%0d exp=%0d", s, start_sel_q[s], g[s]); end
    end
    repeat (60) @(negedge clk); #1;
    total++;
    if (obs_q.size() !== 5) begin bad++; $display("FAIL rr_count got=%0d exp=5", obs_q.size()); end
  endtask

  task automatic test_rr_skip();
    bit ok;
    int k;
    int g[3];
    logic [NCH-1:0] e;
    do_reset();
    adc_rand = 1'b1;
    g[0] = ref_pick(0, 4'b0001);
    g[1] = ref_pick((g[0] + 1) % NCH, 4'b0101);
    g[2] = ref_pick((g[1] + 1) % NCH, 4'b0001);
    bus.req = 4'b0001;
    wait_deliv(1, 400, ok);
    bus.req = 4'b0101;
    k = 0;
    while (busy_rise_q.size() < 2 && k < 20) begin @(negedge clk); #1; k++; end
    bus.req = 4'b0001;
    wait_deliv(3, 800, ok);
    bus.req = '0;
    total++;
    if (!ok) begin bad++; $display("FAIL skip_timeout got=%0d exp=3", obs_q.size()); return; end
    for (int s = 0; s < 3; s++) begin
      e = NCH'(1) << g[s];
      total++;
      if (obs_q[s].oh !== e) begin bad++; $display("FAIL skip_grant s=%0d got=%b exp=%b", s, obs_q[s].oh, e); end
      total++;
      if (obs_q[s].data !== exp_adc_q[s]) begin bad++; $display("FAIL skip_data s=%0d got=%h exp=%h", s, obs_q[s].data, exp_adc_q[s]); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    adc_rand = 1'b1;
    bus.req  = 4'b0100;
    wait_deliv(2, 800, ok);
    bus.req = '0;
    total++;
    if (!ok) begin bad++; $display("FAIL b2b_timeout got=%0d exp=2", obs_q.size()); return; end
    total++;
    if (obs_q[0].oh !== 4'b0100 || obs_q[1].oh !== 4'b0100) begin bad++; $display("FAIL b2b_grant got=%b,%b exp=0100,0100", obs_q[0].oh, obs_q[1].oh); end
    total++;
    if (busy_rise_q.size() < 2 || busy_rise_q[1] - obs_q[0].t !== 1) begin bad++; $display("FAIL b2b_idle_len got=%0d exp=1", busy_rise_q.size() >= 2 ? busy_rise_q[1] - obs_q[0].t : -1); end
  endtask

  task automatic test_reset_wait();
    int k;
    do_reset();
    adc_rand = 1'b0; adc_conv = 30; adc_val = 16'h1234;
    bus.req = 4'b0001;
    k = 0;
    while (start_t_q.size() < 1 && k < 100) begin @(negedge clk); #1; k++; end
    bus.req = '0;
    total++;
    if (start_t_q.size() < 1) begin bad++; $display("FAIL rstw_no_start got=0 exp=1"); return; end
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    total++;
    if (bus.busy !== 1'b0 || bus.rd_valid !== '0) begin bad++; $display("FAIL rstw_busy got=%b/%b exp=0/0", bus.busy, bus.rd_valid); end
    reset = 1'b0;
    k = 0;
    while (model_busy && k < 100) begin @(negedge clk); #1; k++; end
    repeat (10) @(negedge clk); #1;
    total++;
    if (obs_q.size() !== 0) begin bad++; $display("FAIL rstw_no_deliver got=%0d exp=0", obs_q.size()); end
    total++;
    if (busy_rise_q.size() !== 1 || bus.busy !== 1'b0) begin bad++; $display("FAIL rstw_stay_idle got=%0d exp=1", busy_rise_q.size()); end
  endtask

`ifdef ADC_TIMEOUT_EN
  task automatic test_timeout();
    int k;
    int t_err;
    do_reset();
    adc_respond = 1'b0;
    bus.req = 4'b0010;
    k = 0;
    while (bus.err !== 1'b1 && k < 400) begin @(negedge clk); #1; k++; end
    bus.req = '0;
    t_err = cyc;
    total++;
    if (bus.err !== 1'b1) begin bad++; $display("FAIL to_no_err got=0 exp=1"); adc_respond = 1'b1; return; end
    total++;
    if (start_t_q.size() < 1 || t_err - start_t_q[0] !== int'(TIMEOUT) + 1) begin bad++; $display("FAIL to_latency got=%0d exp=%0d", start_t_q.size() ? t_err - start_t_q[0] : -1, int'(TIMEOUT) + 1); end
    total++;
    if (bus.rd_valid !== 4'b0010 || bus.rd_data !== 16'hFFFF) begin bad++; $display("FAIL to_result got=%b/%h exp=0010/ffff", bus.rd_valid, bus.rd_data); end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL to_busy got=%b exp=0", bus.busy); end
    @(negedge clk); #1;
    total++;
    if (bus.err !== 1'b0) begin bad++; $display("FAIL to_err_width got=%b exp=0", bus.err); end
    adc_respond = 1'b1;
  endtask
`else
  task automatic test_timeout();
    total++;
    if (err_seen !== 0) begin bad++; $display("FAIL err_tied_low got=%0d exp=0", err_seen); end
  endtask
`endif

  initial begin
    bus.req = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_rr_skip();
    test_back_to_back();
    test_reset_wait();
    test_timeout();
    total++;
    if (rv_long !== 0) begin bad++; $display("FAIL rd_valid_width got=%0d exp=0", rv_long); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
